seq_divider: RTL and testbench

Multi-cycle signed integer divider that serves as the responder side of the `data_rdy` / `res_rdy` division handshake used by the acoustic-camera position solver. It accepts one signed dividend/divisor pair per request. It produces one quotient bit per clock using restoring division, then returns a truncate-toward-zero quotient and remainder with a single-cycle `res_rdy` pulse. One instance serves all sequential divisions of the solver: distance, R, x and y.

---
 rtl/div_pkg.sv | 20 ++
 rtl/seq_divider.sv | 143 ++++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
package div_pkg;

  // Controller states: waiting for a request, iterating, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default operand widths used by the position solver.
  localparam int DIV_N_DEF = 32;
  localparam int DIV_M_DEF = 32;

  // Iteration counter width for a given quotient width.
  function automatic int div_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring division, one quotient bit per clock,
// truncate-toward-zero quotient, remainder carrying the dividend's sign.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEF,  // dividend / quotient width, N >= M, N >= 2
  parameter int M = DIV_M_DEF   // divisor / remainder width
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_rdy,
  input  logic signed [N-1:0] dividend,
  input  logic signed [M-1:0] divisor,
  output logic                res_rdy,
  output logic signed [N-1:0] merchant,
  output logic signed [M-1:0] remainder,
  output logic                busy,
  output logic                div_by_zero
);

  localparam int               CNT_W    = div_cnt_w(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  // Saturated quotients returned for a zero divisor.
  localparam logic [N-1:0]     SAT_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     SAT_NEG  = {1'b1, {(N-1){1'b0}}};

  div_state_t       r_state;
  logic [N-1:0]     r_quo;        // dividend magnitude, becomes quotient magnitude
  logic [M-1:0]     r_rem;        // partial remainder, always < |divisor|
  logic [M-1:0]     r_dvs;        // divisor magnitude
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dvz;
  logic             r_res_rdy;
  logic             r_busy;
  logic [N-1:0]     r_merchant;
  logic [M-1:0]     r_remainder;
  logic             r_div_by_zero;

  logic [N-1:0]     w_dvd_abs;
  logic [M-1:0]     w_dvs_abs;
  logic             w_dvs_zero;
  logic [M:0]       w_shift;
  logic             w_ge;
  logic [M-1:0]     w_diff;
  logic [M-1:0]     w_rem_next;
  logic [N-1:0]     w_merchant;
  logic [M-1:0]     w_remainder;

  // Operand magnitudes. Read as unsigned, an N-bit negation already yields
  // 2^(N-1) for the most negative dividend, so no extra magnitude bit is kept.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    w_dvd_abs  = dividend[N-1] ? -dividend : dividend;
    w_dvs_abs  = divisor[M-1]  ? -divisor  : divisor;
    w_dvs_zero = (divisor == '0);
  end

  // One restoring step: shift in the next dividend bit, trial-subtract |divisor|,
  // keep the difference when it does not go negative.
  always_comb begin
    w_shift    = {r_rem, r_quo[N-1]};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_diff     = w_shift[M-1:0] - r_dvs;
    w_rem_next = w_ge ? w_diff : w_shift[M-1:0];
  end

  // Sign correction of the final magnitudes, or the divide-by-zero result.
  always_comb begin
    w_merchant  = r_q_neg ? -r_quo : r_quo;
    w_remainder = r_r_neg ? -r_rem : r_rem;
    if (r_dvz) begin
      w_merchant  = r_r_neg ? SAT_NEG : SAT_POS;
      // Low M bits of the dividend rebuilt from its stored magnitude.
      w_remainder = r_r_neg ? -r_quo[M-1:0] : r_quo[M-1:0];
    end
  end

  // Controller and datapath: accept in IDLE, iterate in CALC, publish from DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_quo         <= '0;
      r_rem         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dvz         <= 1'b0;
      r_res_rdy     <= 1'b0;
      r_busy        <= 1'b0;
      r_merchant    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      r_res_rdy <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (data_rdy) begin
            r_quo   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_q_neg <= dividend[N-1] ^ divisor[M-1];
            r_r_neg <= dividend[N-1];
            r_dvz   <= w_dvs_zero;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= w_dvs_zero ? DONE : CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[N-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_merchant    <= w_merchant;
          r_remainder   <= w_remainder;
          r_div_by_zero <= r_dvz;
          r_res_rdy     <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign res_rdy     = r_res_rdy;
  assign merchant    = r_merchant;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with N = M = 32.
module tb_seq_divider;

  logic               clk;
  logic               rst_n;
  logic               data_rdy;
  logic signed [31:0] dividend;
  logic signed [31:0] divisor;
  logic               res_rdy;
  logic signed [31:0] merchant;
  logic signed [31:0] remainder;
  logic               busy;
  logic               div_by_zero;

  int n_tests;
  int n_fail;

  seq_divider #(.N(32), .M(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_rdy    (data_rdy),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_rdy     (res_rdy),
    .merchant    (merchant),
    .remainder   (remainder),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence needs well under 2000 cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, count edges to res_rdy, check results and the pulse width.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dvz, input int exp_lat);
    int lat;
    @(negedge clk);
    data_rdy = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    data_rdy = 1'b0;
    dividend = $urandom;   // later operand changes must not matter
    divisor  = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (res_rdy) break;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " merchant"}, merchant, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dvz));
    @(posedge clk);
    #1;
    check({tag, " pulse width"}, 32'(res_rdy), 32'd0);
    check({tag, " merchant held"}, merchant, exp_q);
  endtask

  initial begin
    int lat;
    int extra;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    data_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset res_rdy", 32'(res_rdy), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset merchant", merchant, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and signed divisions, 33 edges from sampling to res_rdy
    do_div("7/2",   32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33);
    do_div("-7/2",  32'(-7),      32'd2,        32'(-3),      32'(-1),      1'b0, 33);
    do_div("7/-2",  32'd7,        32'(-2),      32'(-3),      32'd1,        1'b0, 33);
    do_div("-7/-2", 32'(-7),      32'(-2),      32'd3,        32'(-1),      1'b0, 33);
    do_div("solver", 32'd12340000, 32'd93750,   32'd131,      32'd58750,    1'b0, 33);
    do_div("0/5",   32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33);

    // Divide by zero: saturated quotient, dividend as remainder, one edge latency
    do_div("5/0",   32'd5,        32'd0,        32'h7FFF_FFFF, 32'd5,       1'b1, 1);
    do_div("-5/0",  32'(-5),      32'd0,        32'h8000_0000, 32'hFFFF_FFFB, 1'b1, 1);

    // Most negative dividend
    do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,    1'b0, 33);
    do_div("min/1",  32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,    1'b0, 33);

    // Request while busy is ignored: 100/7 must complete untouched
    @(negedge clk);
    data_rdy = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    data_rdy = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data_rdy = 1'b1;
    dividend = 32'd1;
    divisor  = 32'd1;
    @(posedge clk);
    #1;
    lat++;
    data_rdy = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (res_rdy) break;
    end
    check("busy req latency", 32'(lat), 32'd33);
    check("busy req merchant", merchant, 32'd14);
    check("busy req remainder", remainder, 32'd2);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_rdy) extra++;
    end
    check("busy req not queued", 32'(extra), 32'd0);

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    data_rdy = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    data_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset res_rdy", 32'(res_rdy), 32'd0);
    check("mid reset merchant", merchant, 32'd0);
    check("mid reset remainder", remainder, 32'd0);
    check("mid reset div_by_zero", 32'(div_by_zero), 32'd0);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_rdy) extra++;
    end
    check("mid reset discarded", 32'(extra), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // New request after reset
    do_div("after reset", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
